// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
// The polarity helper maps active-high decoder patterns onto the pins.
package seg7_pkg;

    typedef enum logic {
        BLANK,
        SHOW
    } scan_state_e;

    localparam logic [6:0] SEG_OFF_CA = 7'h7F;
    localparam logic [6:0] SEG_OFF_CC = 7'h00;

    function automatic logic [6:0] seg_pol(
        input logic [6:0] seg,
        input logic       common_anode
    );
        return common_anode ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Digit slot timer: counts cycles within a slot, steps the digit index,
// and flags slot boundaries plus a registered end-of-frame pulse.
module seg7_slot_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 48
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [$clog2(REFRESH_DIV)-1:0] slot_cnt,
    output logic [$clog2(NUM_DIGITS)-1:0]  idx,
    output logic                          slot_start,
    output logic                          show_next,
    output logic                          slot_end,
    output logic                          frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          frame_done_q, frame_done_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        // Predicted from next-state so the flop lines up with the last cycle
        frame_done_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign slot_cnt   = cnt_q;
    assign idx        = idx_q;
    assign slot_start = (cnt_q == '0);
    assign show_next  = (cnt_q == CNT_SHOW);
    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_done = frame_done_q;

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scans a shared BCD decoder across the display digits with blanking gaps,
// tear-free frame-boundary updates and leading-zero suppression.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 48,
    parameter int COMMON_ANODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    blank_lz,
    output logic [3:0]              bcd_out,
    input  logic [6:0]              seg_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic       CA      = (COMMON_ANODE != 0);
    localparam logic [6:0] SEG_OFF = CA ? SEG_OFF_CA : SEG_OFF_CC;
    localparam logic       DP_OFF  = CA;
    localparam logic       DP_ON   = !CA;

    logic [CW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    logic          slot_start;
    logic          show_next;
    logic          slot_end;

    seg7_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .slot_cnt  (slot_cnt),
        .idx       (idx),
        .slot_start(slot_start),
        .show_next (show_next),
        .slot_end  (slot_end),
        .frame_done(frame_done)
    );

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    pend_full_q, pend_full_d;
    logic [3:0]              bcd_q, bcd_d;
    logic [6:0]              pat_q, pat_d, seg_out_q, seg_out_d;
    logic                    dp_cur_q, dp_cur_d, lz_q, lz_d;
    logic                    dp_out_q, dp_out_d;
    scan_state_e             state_q, state_d;
    logic                    hi_zero;

    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        bcd_d       = bcd_q;
        pat_d       = pat_q;
        dp_cur_d    = dp_cur_q;
        lz_d        = lz_q;
        state_d     = state_q;

        hi_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx) && shadow_q[i*4 +: 4] != 4'd0) begin
                hi_zero = 1'b0;
            end
        end

        if (load_valid && !pend_full_q) begin
            pend_d      = load_value;
            pend_dp_d   = load_dp;
            pend_full_d = 1'b1;
        end
        // Shadow only moves between frames so a scan never mixes values
        if (frame_done && pend_full_q) begin
            shadow_d    = pend_q;
            shadow_dp_d = pend_dp_q;
            pend_full_d = 1'b0;
        end

        if (slot_start) begin
            bcd_d    = shadow_q[int'(idx)*4 +: 4];
            dp_cur_d = shadow_dp_q[idx];
            lz_d     = blank_lz && (idx != '0) && hi_zero;
        end
        if (slot_cnt == CW'(1)) begin
            pat_d = seg_in;
        end

        unique case (state_q)
            BLANK: if (show_next) state_d = SHOW;
            SHOW:  if (slot_end)  state_d = BLANK;
        endcase

        digit_en_d = '0;
        seg_out_d  = SEG_OFF;
        dp_out_d   = DP_OFF;
        if (state_d == SHOW) begin
            // A suppressed zero with its point set still lights the point
            if (!lz_d || dp_cur_d) digit_en_d = NUM_DIGITS'(1) << idx;
            if (!lz_d)             seg_out_d  = seg_pol(pat_d, CA);
            if (dp_cur_d)          dp_out_d   = DP_ON;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            pend_q      <= '0;
            pend_dp_q   <= '0;
            pend_full_q <= 1'b0;
            bcd_q       <= '0;
            pat_q       <= '0;
            dp_cur_q    <= 1'b0;
            lz_q        <= 1'b0;
            state_q     <= BLANK;
            digit_en_q  <= '0;
            seg_out_q   <= SEG_OFF;
            dp_out_q    <= DP_OFF;
        end else begin
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            pend_q      <= pend_d;
            pend_dp_q   <= pend_dp_d;
            pend_full_q <= pend_full_d;
            bcd_q       <= bcd_d;
            pat_q       <= pat_d;
            dp_cur_q    <= dp_cur_d;
            lz_q        <= lz_d;
            state_q     <= state_d;
            digit_en_q  <= digit_en_d;
            seg_out_q   <= seg_out_d;
            dp_out_q    <= dp_out_d;
        end
    end

    assign load_ready = !pend_full_q;
    assign bcd_out    = bcd_q;
    assign seg_out    = seg_out_q;
    assign dp_out     = dp_out_q;
    assign digit_en   = digit_en_q;

endmodule
